demux_vc: RTL and testbench

DEMUX_VC -- requirements
Module: demux_vc

---
 rtl/demux_vc.sv | 159 +++++++++++++++
 tb/tb_demux_vc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux_vc.sv
// demux_vc: routes words from an upstream mux into one of two virtual-channel FIFOs.
//
// Bit DATA_SIZE-1 of each word selects the channel (0 -> VC0, 1 -> VC1). The whole word,
// including the routing bit, is forwarded unmodified with a one-cycle latency. If the target
// FIFO reports almost_full when a word is accepted, the word is parked in a one-entry hold
// register. The block then stops accepting until that word has been pushed.
//
// Optional feature: define DEMUX_VC_COUNT_EN to enable the saturating per-VC push counters.
// Without it, count_VC0/count_VC1 are tied to zero and no counter logic exists.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-high reset
//   data_in          word from upstream; MSB selects the VC
//   valid_in         data_in is valid this cycle
//   ready_in         block can accept a word this cycle (FSM in PASS)
//   almost_full_VC0  VC0 FIFO cannot take another word
//   almost_full_VC1  VC1 FIFO cannot take another word
//   data_VC0/1       word to the VC FIFO (all zeros when not pushing)
//   push_VC0/1       write strobe to the VC FIFO
//   count_VC0/1      saturating count of words pushed to each VC

module demux_vc #(
    parameter int unsigned DATA_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic                 almost_full_VC0,
    input  logic                 almost_full_VC1,
    output logic [DATA_SIZE-1:0] data_VC0,
    output logic                 push_VC0,
    output logic [DATA_SIZE-1:0] data_VC1,
    output logic                 push_VC1,
    output logic [7:0]           count_VC0,
    output logic [7:0]           count_VC1
);

    localparam logic [0:0] PASS = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [DATA_SIZE-1:0] hold_q, hold_d;

    logic                 push_vc0_q, push_vc0_d;
    logic                 push_vc1_q, push_vc1_d;
    logic [DATA_SIZE-1:0] data_vc0_q, data_vc0_d;
    logic [DATA_SIZE-1:0] data_vc1_q, data_vc1_d;

    // Word selected for forwarding this cycle (either the new input or the held word).
    logic                 fwd_valid;
    logic [DATA_SIZE-1:0] fwd_word;

    // Only the target VC's almost_full is consulted; the other channel's flag is ignored.
    logic in_full;
    logic hold_full;

    assign in_full   = data_in[DATA_SIZE-1] ? almost_full_VC1 : almost_full_VC0;
    assign hold_full = hold_q[DATA_SIZE-1]  ? almost_full_VC1 : almost_full_VC0;

    // ----------------------------------------------------------------------------------------
    // Next-state logic
    // ----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        fwd_valid = 1'b0;
        fwd_word  = '0;

        if (state_q == PASS) begin
            if (valid_in) begin
                if (in_full) begin
                    hold_d  = data_in;
                    state_d = HOLD;
                end else begin
                    fwd_valid = 1'b1;
                    fwd_word  = data_in;
                end
            end
        end else begin
            // valid_in is deliberately ignored here: ready_in is low while holding.
            if (!hold_full) begin
                fwd_valid = 1'b1;
                fwd_word  = hold_q;
                hold_d    = '0;
                state_d   = PASS;
            end
        end
    end

    // Route the forwarded word. The two pushes are mutually exclusive by construction,
    // because a single word drives at most one of them.
    always_comb begin
        push_vc0_d = fwd_valid & ~fwd_word[DATA_SIZE-1];
        push_vc1_d = fwd_valid &  fwd_word[DATA_SIZE-1];
        data_vc0_d = push_vc0_d ? fwd_word : '0;
        data_vc1_d = push_vc1_d ? fwd_word : '0;
    end

    // ----------------------------------------------------------------------------------------
    // State and output registers
    // ----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PASS;
            hold_q     <= '0;
            push_vc0_q <= 1'b0;
            push_vc1_q <= 1'b0;
            data_vc0_q <= '0;
            data_vc1_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            push_vc0_q <= push_vc0_d;
            push_vc1_q <= push_vc1_d;
            data_vc0_q <= data_vc0_d;
            data_vc1_q <= data_vc1_d;
        end
    end

    assign ready_in = (state_q == PASS);
    assign push_VC0 = push_vc0_q;
    assign push_VC1 = push_vc1_q;
    assign data_VC0 = data_vc0_q;
    assign data_VC1 = data_vc1_q;

    // ----------------------------------------------------------------------------------------
    // Optional push counters
    // ----------------------------------------------------------------------------------------
`ifdef DEMUX_VC_COUNT_EN
    logic [7:0] count_vc0_q;
    logic [7:0] count_vc1_q;

    // Each counter advances at the end of a cycle in which its push strobe is high,
    // and sticks at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_vc0_q <= 8'd0;
            count_vc1_q <= 8'd0;
        end else begin
            if (push_vc0_q && (count_vc0_q != 8'hFF)) begin
                count_vc0_q <= count_vc0_q + 8'd1;
            end
            if (push_vc1_q && (count_vc1_q != 8'hFF)) begin
                count_vc1_q <= count_vc1_q + 8'd1;
            end
        end
    end

    assign count_VC0 = count_vc0_q;
    assign count_VC1 = count_vc1_q;
`else
    assign count_VC0 = 8'd0;
    assign count_VC1 = 8'd0;
`endif

endmodule

// File: tb/tb_demux_vc.sv
// Directed self-checking bench for demux_vc (DATA_SIZE = 4).
module tb_demux_vc;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_in;
    logic         almost_full_VC0;
    logic         almost_full_VC1;
    logic [W-1:0] data_VC0;
    logic         push_VC0;
    logic [W-1:0] data_VC1;
    logic         push_VC1;
    logic [7:0]   count_VC0;
    logic [7:0]   count_VC1;

    int errors = 0;
    int checks = 0;

`ifdef DEMUX_VC_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    demux_vc #(.DATA_SIZE(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .almost_full_VC0(almost_full_VC0),
        .almost_full_VC1(almost_full_VC1),
        .data_VC0       (data_VC0),
        .push_VC0       (push_VC0),
        .data_VC1       (data_VC1),
        .push_VC1       (push_VC1),
        .count_VC0      (count_VC0),
        .count_VC1      (count_VC1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check("push_excl", {31'd0, push_VC0 & push_VC1}, 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic p0, input logic [W-1:0] d0,
                              input logic p1, input logic [W-1:0] d1, input logic rdy);
        check({tag, ".push0"}, {31'd0, push_VC0}, {31'd0, p0});
        check({tag, ".data0"}, {28'd0, data_VC0}, {28'd0, d0});
        check({tag, ".push1"}, {31'd0, push_VC1}, {31'd0, p1});
        check({tag, ".data1"}, {28'd0, data_VC1}, {28'd0, d1});
        check({tag, ".ready"}, {31'd0, ready_in}, {31'd0, rdy});
    endtask

    initial begin
        reset           = 1'b1;
        data_in         = '0;
        valid_in        = 1'b0;
        almost_full_VC0 = 1'b0;
        almost_full_VC1 = 1'b0;
        tick();
        tick();
        expect_out("reset", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        check("reset.cnt0", {24'd0, count_VC0}, 32'd0);
        check("reset.cnt1", {24'd0, count_VC1}, 32'd0);
        reset = 1'b0;

        // Single word to VC0, latency 1.
        data_in = 4'b0101; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        expect_out("single", 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        tick();
        expect_out("single_idle", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Back-to-back A, 3, F.
        data_in = 4'hA; valid_in = 1'b1;
        tick();
        expect_out("b2b_A", 1'b0, 4'h0, 1'b1, 4'hA, 1'b1);
        data_in = 4'h3;
        tick();
        expect_out("b2b_3", 1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
        data_in = 4'hF;
        tick();
        expect_out("b2b_F", 1'b0, 4'h0, 1'b1, 4'hF, 1'b1);
        valid_in = 1'b0;
        tick();
        expect_out("b2b_idle", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Backpressure on VC1; a VC0 word offered during HOLD must be ignored.
        almost_full_VC1 = 1'b1; data_in = 4'hC; valid_in = 1'b1;
        tick();
        expect_out("bp_hold0", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        data_in = 4'h1;
        tick();
        expect_out("bp_hold1", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        expect_out("bp_hold2", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        almost_full_VC1 = 1'b0; valid_in = 1'b0;
        tick();
        expect_out("bp_release", 1'b0, 4'h0, 1'b1, 4'hC, 1'b1);
        tick();
        expect_out("bp_after", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Cross-VC backpressure has no effect.
        almost_full_VC1 = 1'b1; data_in = 4'h2; valid_in = 1'b1;
        tick();
        expect_out("cross_vc0", 1'b1, 4'h2, 1'b0, 4'h0, 1'b1);
        almost_full_VC1 = 1'b0; almost_full_VC0 = 1'b1; data_in = 4'hB;
        tick();
        expect_out("cross_vc1", 1'b0, 4'h0, 1'b1, 4'hB, 1'b1);
        almost_full_VC0 = 1'b0; valid_in = 1'b0;
        tick();

        // Reset while holding discards the held word.
        almost_full_VC1 = 1'b1; data_in = 4'h9; valid_in = 1'b1;
        tick();
        expect_out("rst_hold", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        valid_in = 1'b0; reset = 1'b1;
        tick();
        expect_out("rst_pulse", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        check("rst_pulse.cnt0", {24'd0, count_VC0}, 32'd0);
        check("rst_pulse.cnt1", {24'd0, count_VC1}, 32'd0);
        reset = 1'b0; almost_full_VC1 = 1'b0;
        tick();
        expect_out("rst_drop0", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        expect_out("rst_drop1", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Word presented with reset high is not accepted.
        reset = 1'b1; data_in = 4'h5; valid_in = 1'b1;
        tick();
        reset = 1'b0; valid_in = 1'b0;
        tick();
        expect_out("rst_word", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Counters: 10 words, then 290 more to reach saturation.
        data_in = 4'h1; valid_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        valid_in = 1'b0;
        tick();
        tick();
        check("cnt10.cnt0", {24'd0, count_VC0}, CNT_EN ? 32'd10 : 32'd0);
        check("cnt10.cnt1", {24'd0, count_VC1}, 32'd0);
        valid_in = 1'b1;
        for (int i = 0; i < 290; i++) tick();
        valid_in = 1'b0;
        tick();
        tick();
        check("sat.cnt0", {24'd0, count_VC0}, CNT_EN ? 32'd255 : 32'd0);
        check("sat.cnt1", {24'd0, count_VC1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
